// File: rtl/decoder_seq_pkg.sv
// Shared defines for the sequencer decoder: FSM states, opcode fields and
// ALU operand-select codes.
package decoder_seq_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // ALU operand select: codes 0..3 address a general register directly.
    localparam logic [2:0] SEL_IN   = 3'd4;
    localparam logic [2:0] SEL_ZERO = 3'd5;

    // Opcode class, op[3:2].
    localparam logic [1:0] OP_CLS_ADD_IM = 2'b00;
    localparam logic [1:0] OP_CLS_MOV_IM = 2'b01;
    localparam logic [1:0] OP_CLS_MOV_IN = 2'b10;
    localparam logic [1:0] OP_CLS_CTRL   = 2'b11;

    // Control-class sub-op, op[1:0] when the class is OP_CLS_CTRL.
    localparam logic [1:0] OP_SUB_JMP  = 2'b00;
    localparam logic [1:0] OP_SUB_JNC  = 2'b01;
    localparam logic [1:0] OP_SUB_OUT  = 2'b10;
    localparam logic [1:0] OP_SUB_HALT = 2'b11;

endpackage

// File: rtl/decoder_seq_op_table.sv
// Combinational opcode-to-control table. Register-class ops addressing a
// register that does not exist decode as a NOP with the illegal bit set.
module op_table #(
    parameter int NREG = 2
) (
    input  logic [3:0] op,
    input  logic       carry,
    output logic [2:0] sel,
    output logic       load_en,
    output logic [1:0] load_idx,
    output logic       pc_load,
    output logic       out_load,
    output logic       halt,
    output logic       illegal
);
    import decoder_seq_pkg::*;

    // Map the opcode and latched carry onto datapath control bits.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        sel      = SEL_ZERO;
        load_en  = 1'b0;
        load_idx = op[1:0];
        pc_load  = 1'b0;
        out_load = 1'b0;
        halt     = 1'b0;
        illegal  = 1'b0;
        if (op[3:2] == OP_CLS_CTRL) begin
            case (op[1:0])
                OP_SUB_JMP:  pc_load  = 1'b1;
                OP_SUB_JNC:  pc_load  = ~carry;
                OP_SUB_OUT:  out_load = 1'b1;
                default:     halt     = 1'b1;
            endcase
        end else if (int'(op[1:0]) >= NREG) begin
            illegal = 1'b1;
        end else begin
            load_en = 1'b1;
            case (op[3:2])
                OP_CLS_ADD_IM: sel = {1'b0, op[1:0]};
                OP_CLS_MOV_IM: sel = SEL_ZERO;
                default:       sel = SEL_IN;
            endcase
        end
    end

endmodule

// File: rtl/decoder_seq.sv
// Two-cycle instruction sequencer: FETCH accepts a word, EXEC drives the
// one-cycle control strobes, HALT parks until resume. Also keeps a sticky
// illegal-opcode flag and a saturating retired-instruction counter.
module decoder_seq #(
    parameter int NREG  = 2,
    parameter int IMM_W = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [IMM_W+3:0]   instr_in,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic               carry_in,
    input  logic               resume,
    output logic [2:0]         alu_data_sel,
    output logic [NREG-1:0]    reg_load,
    output logic               pc_load,
    output logic               out_load,
    output logic [IMM_W-1:0]   imm_out,
    output logic               halted,
    output logic               illegal,
    output logic [CNT_W-1:0]   retired
);
    import decoder_seq_pkg::*;

    state_t           state, state_nxt;
    logic [3:0]       op_q;
    logic             carry_q;
    logic [IMM_W-1:0] imm_q;
    logic             illegal_q;
    logic [CNT_W-1:0] retired_q;

    logic       accept, exec;
    logic [2:0] tbl_sel;
    logic       tbl_load_en, tbl_pc, tbl_out, tbl_halt, tbl_illegal;
    logic [1:0] tbl_load_idx;

    assign accept = (state == ST_FETCH) && instr_valid;
    assign exec   = (state == ST_EXEC);

    op_table #(.NREG(NREG)) u_op_table (
        .op       (op_q),
        .carry    (carry_q),
        .sel      (tbl_sel),
        .load_en  (tbl_load_en),
        .load_idx (tbl_load_idx),
        .pc_load  (tbl_pc),
        .out_load (tbl_out),
        .halt     (tbl_halt),
        .illegal  (tbl_illegal)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) state <= ST_FETCH;
        else       state <= state_nxt;
    end

    // Next-state logic: one instruction per FETCH/EXEC pair, HALT parks.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_FETCH: if (instr_valid) state_nxt = ST_EXEC;
            ST_EXEC:  state_nxt = tbl_halt ? ST_HALT : ST_FETCH;
            ST_HALT:  if (resume) state_nxt = ST_FETCH;
            default:  state_nxt = ST_FETCH;
        endcase
    end

    // Latch the accepted opcode, carry and immediate; imm_q holds between instructions.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q    <= '0;
            carry_q <= 1'b0;
            imm_q   <= '0;
        end else if (accept) begin
            op_q    <= instr_in[IMM_W+3:IMM_W];
            carry_q <= carry_in;
            imm_q   <= instr_in[IMM_W-1:0];
        end
    end

    // Sticky illegal flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset)                    illegal_q <= 1'b0;
        else if (exec && tbl_illegal) illegal_q <= 1'b1;
    end

    // Retired counter bumps on entry to EXEC so the count is already visible
    // during the instruction's own EXEC cycle; a reset in EXEC clears it.
    always_ff @(posedge clk) begin
        if (reset)                         retired_q <= '0;
        else if (accept && retired_q != '1) retired_q <= retired_q + CNT_W'(1);
    end

    // Strobes and operand select are live only in EXEC.
    always_comb begin
        alu_data_sel = exec ? tbl_sel : SEL_ZERO;
        pc_load      = exec && tbl_pc;
        out_load     = exec && tbl_out;
        for (int i = 0; i < NREG; i++) begin
            reg_load[i] = exec && tbl_load_en && (tbl_load_idx == 2'(i));
        end
    end

    assign instr_ready = (state == ST_FETCH);
    assign halted      = (state == ST_HALT);
    assign illegal     = illegal_q || (exec && tbl_illegal);
    assign imm_out     = imm_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_decoder_seq.sv
// Directed-vector bench for decoder_seq: default configuration plus a
// 3-bit-counter instance for saturation.
module tb_decoder_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance (NREG=2, IMM_W=4, CNT_W=16).
    logic        reset, instr_valid, carry_in, resume;
    logic [7:0]  instr_in;
    logic        instr_ready, pc_load, out_load, halted, illegal;
    logic [2:0]  alu_data_sel;
    logic [1:0]  reg_load;
    logic [3:0]  imm_out;
    logic [15:0] retired;

    // Saturation instance (CNT_W=3).
    logic        reset2, valid2, carry2, resume2;
    logic [7:0]  instr2;
    logic        ready2, pc2, out2, halted2, illegal2;
    logic [2:0]  sel2;
    logic [1:0]  reg_load2;
    logic [3:0]  imm2;
    logic [2:0]  retired2;

    decoder_seq #(.NREG(2), .IMM_W(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .carry_in(carry_in), .resume(resume),
        .alu_data_sel(alu_data_sel), .reg_load(reg_load), .pc_load(pc_load),
        .out_load(out_load), .imm_out(imm_out), .halted(halted), .illegal(illegal),
        .retired(retired)
    );

    decoder_seq #(.NREG(2), .IMM_W(4), .CNT_W(3)) dut_sat (
        .clk(clk), .reset(reset2), .instr_in(instr2), .instr_valid(valid2),
        .instr_ready(ready2), .carry_in(carry2), .resume(resume2),
        .alu_data_sel(sel2), .reg_load(reg_load2), .pc_load(pc2),
        .out_load(out2), .imm_out(imm2), .halted(halted2), .illegal(illegal2),
        .retired(retired2)
    );

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_ret;

    // Outputs captured by issue(): acceptance cycle and EXEC cycle.
    logic        s_ready, s_pc, s_out, s_illegal, s_halted;
    logic [1:0]  s_reg_load;
    logic [2:0]  s_sel;
    logic [3:0]  s_imm;
    logic [15:0] s_retired;

    // Present one instruction in FETCH, then capture the EXEC-cycle outputs.
    // Starts and ends just after a rising edge. Carry flips after acceptance
    // so only the latched value can drive JNC.
    task automatic issue(input logic [3:0] op, input logic [3:0] imm, input logic c);
        instr_in = {op, imm}; instr_valid = 1'b1; carry_in = c;
        @(negedge clk);
        s_ready = instr_ready;
        @(posedge clk); #1;
        instr_valid = 1'b0; carry_in = ~c; instr_in = 8'h00;
        @(negedge clk);
        s_reg_load = reg_load; s_sel = alu_data_sel; s_pc = pc_load; s_out = out_load;
        s_imm = imm_out; s_illegal = illegal; s_halted = halted; s_retired = retired;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0d exp 1", instr_ready); end
        checks++; if (alu_data_sel !== 3'd5) begin errors++; $display("FAIL rst_sel: got %0d exp 5", alu_data_sel); end
        checks++; if ({reg_load, pc_load, out_load} !== 4'b0) begin errors++; $display("FAIL rst_strobes: got %b exp 0000", {reg_load, pc_load, out_load}); end
        checks++; if (imm_out !== 4'd0) begin errors++; $display("FAIL rst_imm: got %0d exp 0", imm_out); end
        checks++; if ({halted, illegal} !== 2'b00) begin errors++; $display("FAIL rst_flags: got %b exp 00", {halted, illegal}); end
        checks++; if (retired !== 16'd0) begin errors++; $display("FAIL rst_retired: got %0d exp 0", retired); end
        @(posedge clk); #1;
    endtask

    task automatic test_add_im();
        issue(4'b0000, 4'd3, 1'b0);
        exp_ret++;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL add_ready: got %0d exp 1", s_ready); end
        checks++; if (s_reg_load !== 2'b01) begin errors++; $display("FAIL add_reg_load: got %b exp 01", s_reg_load); end
        checks++; if (s_sel !== 3'd0) begin errors++; $display("FAIL add_sel: got %0d exp 0", s_sel); end
        checks++; if (s_imm !== 4'd3) begin errors++; $display("FAIL add_imm: got %0d exp 3", s_imm); end
        checks++; if ({s_pc, s_out, s_illegal} !== 3'b000) begin errors++; $display("FAIL add_other: got %b exp 000", {s_pc, s_out, s_illegal}); end
        checks++; if (s_retired !== exp_ret) begin errors++; $display("FAIL add_retired: got %0d exp %0d", s_retired, exp_ret); end
        @(negedge clk);
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL add_ready_after: got %0d exp 1", instr_ready); end
        checks++; if ({reg_load, alu_data_sel} !== {2'b00, 3'd5}) begin errors++; $display("FAIL add_idle_outputs: got %b exp 00101", {reg_load, alu_data_sel}); end
        checks++; if (imm_out !== 4'd3) begin errors++; $display("FAIL add_imm_hold: got %0d exp 3", imm_out); end
        @(posedge clk); #1;
    endtask

    task automatic test_moves();
        issue(4'b0101, 4'd5, 1'b0);
        exp_ret++;
        checks++; if ({s_reg_load, s_sel} !== {2'b10, 3'd5}) begin errors++; $display("FAIL movim: got %b exp 10101", {s_reg_load, s_sel}); end
        checks++; if (s_imm !== 4'd5) begin errors++; $display("FAIL movim_imm: got %0d exp 5", s_imm); end
        issue(4'b1000, 4'd10, 1'b0);
        exp_ret++;
        checks++; if ({s_reg_load, s_sel} !== {2'b01, 3'd4}) begin errors++; $display("FAIL movin: got %b exp 01100", {s_reg_load, s_sel}); end
        checks++; if (s_retired !== exp_ret) begin errors++; $display("FAIL movin_retired: got %0d exp %0d", s_retired, exp_ret); end
    endtask

    task automatic test_control();
        issue(4'b1100, 4'd6, 1'b1);
        exp_ret++;
        checks++; if ({s_pc, s_out, s_reg_load, s_sel} !== {1'b1, 1'b0, 2'b00, 3'd5}) begin errors++; $display("FAIL jmp: got %b exp 1000101", {s_pc, s_out, s_reg_load, s_sel}); end
        issue(4'b1101, 4'd9, 1'b0);
        exp_ret++;
        checks++; if ({s_pc, s_imm} !== {1'b1, 4'd9}) begin errors++; $display("FAIL jnc_taken: got %b exp 11001", {s_pc, s_imm}); end
        checks++; if (s_retired !== exp_ret) begin errors++; $display("FAIL jnc_taken_retired: got %0d exp %0d", s_retired, exp_ret); end
        issue(4'b1101, 4'd9, 1'b1);
        exp_ret++;
        checks++; if (s_pc !== 1'b0) begin errors++; $display("FAIL jnc_not_taken: got %0d exp 0", s_pc); end
        checks++; if (s_retired !== exp_ret) begin errors++; $display("FAIL jnc_not_taken_retired: got %0d exp %0d", s_retired, exp_ret); end
        issue(4'b1110, 4'd12, 1'b0);
        exp_ret++;
        checks++; if ({s_out, s_pc, s_reg_load, s_imm} !== {1'b1, 1'b0, 2'b00, 4'd12}) begin errors++; $display("FAIL out_im: got %b exp 10001100", {s_out, s_pc, s_reg_load, s_imm}); end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        logic exp_ready;
        instr_in = {4'b0001, 4'd2}; instr_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            exp_ready = (i % 2 == 0);
            checks++; if (instr_ready !== exp_ready) begin errors++; $display("FAIL b2b_ready[%0d]: got %0d exp %0d", i, instr_ready, exp_ready); end
            if (reg_load == 2'b10) pulses++;
            @(posedge clk); #1;
        end
        instr_valid = 1'b0;
        exp_ret += 3;
        checks++; if (pulses != 3) begin errors++; $display("FAIL b2b_pulses: got %0d exp 3", pulses); end
        checks++; if (retired !== exp_ret) begin errors++; $display("FAIL b2b_retired: got %0d exp %0d", retired, exp_ret); end
    endtask

    task automatic test_illegal();
        issue(4'b0011, 4'd1, 1'b0);
        exp_ret++;
        checks++; if ({s_reg_load, s_pc, s_out} !== 4'b0) begin errors++; $display("FAIL ill_strobes: got %b exp 0000", {s_reg_load, s_pc, s_out}); end
        checks++; if (s_illegal !== 1'b1) begin errors++; $display("FAIL ill_flag: got %0d exp 1", s_illegal); end
        checks++; if (s_retired !== exp_ret) begin errors++; $display("FAIL ill_retired: got %0d exp %0d", s_retired, exp_ret); end
        for (int i = 0; i < 5; i++) begin
            issue(4'b0000, 4'd1, 1'b0);
            exp_ret++;
        end
        @(negedge clk);
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL ill_sticky: got %0d exp 1", illegal); end
        checks++; if (retired !== exp_ret) begin errors++; $display("FAIL ill_retired_after: got %0d exp %0d", retired, exp_ret); end
        @(posedge clk); #1;
    endtask

    task automatic test_halt();
        issue(4'b1111, 4'd0, 1'b0);
        exp_ret++;
        checks++; if ({s_reg_load, s_pc, s_out} !== 4'b0) begin errors++; $display("FAIL halt_strobes: got %b exp 0000", {s_reg_load, s_pc, s_out}); end
        instr_in = {4'b0000, 4'd5}; instr_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if ({instr_ready, halted} !== 2'b01) begin errors++; $display("FAIL halt_hold[%0d]: got %b exp 01", i, {instr_ready, halted}); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++; if (retired !== exp_ret) begin errors++; $display("FAIL halt_retired: got %0d exp %0d", retired, exp_ret); end
        @(posedge clk); #1;
        instr_valid = 1'b0; resume = 1'b1;
        @(posedge clk); #1;
        resume = 1'b0;
        @(negedge clk);
        checks++; if ({instr_ready, halted} !== 2'b10) begin errors++; $display("FAIL resume_state: got %b exp 10", {instr_ready, halted}); end
        @(posedge clk); #1;
        issue(4'b0000, 4'd1, 1'b0);
        exp_ret++;
        checks++; if ({s_ready, s_reg_load} !== 3'b101) begin errors++; $display("FAIL resume_accept: got %b exp 101", {s_ready, s_reg_load}); end
        checks++; if (s_retired !== exp_ret) begin errors++; $display("FAIL resume_retired: got %0d exp %0d", s_retired, exp_ret); end
    endtask

    task automatic test_reset_in_exec();
        instr_in = {4'b1001, 4'd2}; instr_valid = 1'b1;
        @(posedge clk); #1;
        // Now in EXEC; reset wins over a simultaneous valid and resume.
        reset = 1'b1; resume = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; resume = 1'b0; instr_valid = 1'b0;
        exp_ret = 16'd0;
        @(negedge clk);
        checks++; if ({reg_load, pc_load, out_load} !== 4'b0) begin errors++; $display("FAIL rexec_strobes: got %b exp 0000", {reg_load, pc_load, out_load}); end
        checks++; if (retired !== exp_ret) begin errors++; $display("FAIL rexec_retired: got %0d exp 0", retired); end
        checks++; if ({instr_ready, halted, illegal} !== 3'b100) begin errors++; $display("FAIL rexec_state: got %b exp 100", {instr_ready, halted, illegal}); end
        checks++; if ({alu_data_sel, imm_out} !== {3'd5, 4'd0}) begin errors++; $display("FAIL rexec_sel_imm: got %b exp 1010000", {alu_data_sel, imm_out}); end
        @(posedge clk); #1;
    endtask

    task automatic test_saturate();
        int pulses = 0;
        instr2 = {4'b1110, 4'd7}; valid2 = 1'b1;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (out2) pulses++;
            @(posedge clk); #1;
        end
        valid2 = 1'b0;
        @(negedge clk);
        checks++; if (pulses != 9) begin errors++; $display("FAIL sat_pulses: got %0d exp 9", pulses); end
        checks++; if (retired2 !== 3'd7) begin errors++; $display("FAIL sat_retired: got %0d exp 7", retired2); end
        checks++; if (imm2 !== 4'd7) begin errors++; $display("FAIL sat_imm: got %0d exp 7", imm2); end
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; instr_valid = 1'b0; carry_in = 1'b0; resume = 1'b0; instr_in = 8'h00;
        reset2 = 1'b1; valid2 = 1'b0; carry2 = 1'b0; resume2 = 1'b0; instr2 = 8'h00;
        exp_ret = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0; reset2 = 1'b0;
        test_reset();
        test_add_im();
        test_moves();
        test_control();
        test_back_to_back();
        test_illegal();
        test_halt();
        test_reset_in_exec();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
